// File: rtl/manch_tx_framer_if.sv
// Word handshake and line-side signals of the Manchester transmit framer.
interface manch_tx_framer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              tx_manch;
  logic              tx_en;
  logic              busy;
  logic              frame_done;

  modport master (
    output in_data, in_valid,
    input  in_ready, tx_manch, tx_en, busy, frame_done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, tx_manch, tx_en, busy, frame_done
  );
endinterface

// File: rtl/manch_tx_framer.sv
// Manchester transmit framer: preamble, data word, one idle END bit; first half-bit at T+1.
// in_ready only in IDLE or on the final cycle of the last data bit, so a held word streams gaplessly.
module manch_tx_framer #(
  parameter int CLK_FREQ      = 18_750_000,
  parameter int BAUDRATE      = 115200,
  parameter int DATA_W        = 8,
  parameter int PREAMBLE_BITS = 8,
  parameter int POLARITY      = 0,
  parameter int LSB_FIRST     = 1,
  parameter bit IDLE_LEVEL    = 1'b0
) (
  input  logic               mclkin,
  input  logic               rst,
  manch_tx_framer_if.slave   bus
);

  localparam int HALFBAUD = (CLK_FREQ / BAUDRATE) / 2;
  localparam int CW       = (HALFBAUD > 2) ? $clog2(HALFBAUD) : 1;
  localparam int MAXB     = (PREAMBLE_BITS > DATA_W) ? PREAMBLE_BITS : DATA_W;
  localparam int BW       = (MAXB > 2) ? $clog2(MAXB) : 1;

  localparam logic [CW-1:0] HB_LAST   = CW'(HALFBAUD - 1);
  localparam logic [BW-1:0] PRE_LAST  = BW'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic          POL       = (POLARITY != 0);

  if (HALFBAUD < 2) begin : g_bad_baud
    $error("manch_tx_framer: HALFBAUD must be at least 2");
  end
  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
    $error("manch_tx_framer: DATA_W out of range 1..32");
  end
  if (PREAMBLE_BITS < 0 || PREAMBLE_BITS > 64) begin : g_bad_pre
    $error("manch_tx_framer: PREAMBLE_BITS out of range 0..64");
  end

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_END} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_half;
  logic [BW-1:0]       r_bit;
  logic [DATA_W-1:0]   r_shift;
  logic                r_manch;
  logic                r_en;
  logic                r_done;

  state_t              w_state_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_half_nxt;
  logic [BW-1:0]       w_bit_nxt;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                w_manch_nxt;
  logic                w_en_nxt;
  logic                w_done_nxt;
  logic                w_pbit;
  logic                w_dbit;

  logic w_hb_end;
  logic w_bit_end;
  logic w_last_data;
  logic w_ready;
  logic w_xfer;

  assign w_hb_end    = (r_cnt == HB_LAST);
  assign w_bit_end   = w_hb_end && r_half;
  assign w_last_data = (r_state == S_DATA) && w_bit_end && (r_bit == DATA_LAST);
  assign w_ready     = !rst && ((r_state == S_IDLE) || w_last_data);
  assign w_xfer      = w_ready && bus.in_valid;

  always_ff @(posedge mclkin) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_half  <= 1'b0;
      r_bit   <= '0;
      r_shift <= '0;
      r_manch <= IDLE_LEVEL;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_half  <= w_half_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_manch <= w_manch_nxt;
      r_en    <= w_en_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_hb_end ? '0 : r_cnt + CW'(1);
    w_half_nxt  = w_hb_end ? ~r_half : r_half;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt  = '0;
        w_half_nxt = 1'b0;
        w_bit_nxt  = '0;
        if (w_xfer) begin
          w_state_nxt = (PREAMBLE_BITS == 0) ? S_DATA : S_PRE;
          w_shift_nxt = bus.in_data;
        end
      end
      S_PRE: begin
        if (w_bit_end) begin
          if (r_bit == PRE_LAST) begin
            w_state_nxt = S_DATA;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit == DATA_LAST) begin
            w_bit_nxt = '0;
            // A word accepted on the last cycle continues straight into DATA.
            if (w_xfer) begin
              w_shift_nxt = bus.in_data;
            end else begin
              w_state_nxt = S_END;
            end
          end else begin
            w_bit_nxt   = r_bit + BW'(1);
            w_shift_nxt = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);
          end
        end
      end
      S_END: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pbit      = ~w_bit_nxt[0];
    w_dbit      = (LSB_FIRST != 0) ? w_shift_nxt[0] : w_shift_nxt[DATA_W-1];
    w_manch_nxt = IDLE_LEVEL;
    w_en_nxt    = 1'b0;
    w_done_nxt  = (r_state == S_END) && w_bit_end;
    unique case (w_state_nxt)
      S_PRE: begin
        w_en_nxt    = 1'b1;
        w_manch_nxt = (w_half_nxt ^ POL) ? w_pbit : ~w_pbit;
      end
      S_DATA: begin
        w_en_nxt    = 1'b1;
        w_manch_nxt = (w_half_nxt ^ POL) ? w_dbit : ~w_dbit;
      end
      S_END: begin
        w_en_nxt    = 1'b1;
        w_manch_nxt = IDLE_LEVEL;
      end
      default: begin
        w_en_nxt    = 1'b0;
        w_manch_nxt = IDLE_LEVEL;
      end
    endcase
  end

  assign bus.in_ready   = w_ready;
  assign bus.tx_manch   = r_manch;
  assign bus.tx_en      = r_en;
  assign bus.frame_done = r_done;
  assign bus.busy       = (r_state != S_IDLE);

endmodule
